ofdm_rx_byte_packer: RTL

Downstream stage of the OFDM RX path. Consumes the demodulated bit-pair stream (rx_rcv_data / rx_rcv_data_valid / rx_rcv_data_start) and packs each run of 4 pairs into a byte, MSB first. Packed bytes are buffered in a small FIFO and delivered over a valid/ready interface with a start-of-symbol marker. Sticky flags report misaligned symbols and FIFO overflow.

---
 rtl/ofdm_rx_byte_packer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ofdm_rx_byte_packer.sv
// ofdm_rx_byte_packer
//
// Purpose:
//   Last stage of the OFDM receive path. It takes the demodulated bit-pair
//   stream and packs every run of four pairs into one byte, MSB first. Each
//   packed byte carries a start-of-symbol marker. Packed bytes go into a
//   first-word-fall-through FIFO that is drained over a valid/ready
//   interface. The upstream path has no backpressure, so the packer never
//   stalls. If the FIFO is full, the byte is dropped and a sticky flag is
//   raised.
//
// Optional feature (macro RX_PACKER_STATS_EN):
//   When the macro is defined, the block adds the 16-bit saturating outputs
//   sym_count and drop_count. When it is undefined, those ports and counters
//   do not exist.
//
// Ports:
//   sys_clk            system clock, rising edge
//   sys_rst            asynchronous active-high reset
//   sys_init           synchronous flush of packer, FIFO and sticky flags
//   rx_rcv_data        demodulated bit pair
//   rx_rcv_data_valid  pair valid this cycle
//   rx_rcv_data_start  first pair of a symbol (qualified by valid)
//   out_data           FIFO head byte (0 when empty)
//   out_sof            FIFO head is the first byte of a symbol (0 when empty)
//   out_valid          FIFO head valid
//   out_ready          consumer accepts head
//   fill_level         FIFO occupancy, 0..fifo_depth_c
//   misalign_err       sticky: symbol start arrived with a partial byte pending
//   ovf_err            sticky: byte dropped on a full FIFO
//   clear_err          synchronous clear of both sticky flags
//   sym_count          (stats only) accepted symbol starts, saturating
//   drop_count         (stats only) dropped or discarded bytes, saturating

module ofdm_rx_byte_packer #(
    parameter int bits_per_sym_c = 2,
    parameter int fifo_depth_c   = 16,
    parameter int fill_width_c   = $clog2(fifo_depth_c) + 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      sys_init,
    input  logic [bits_per_sym_c-1:0] rx_rcv_data,
    input  logic                      rx_rcv_data_valid,
    input  logic                      rx_rcv_data_start,
    output logic [7:0]                out_data,
    output logic                      out_sof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [fill_width_c-1:0]   fill_level,
    output logic                      misalign_err,
    output logic                      ovf_err,
    input  logic                      clear_err
`ifdef RX_PACKER_STATS_EN
    ,
    output logic [15:0]               sym_count,
    output logic [15:0]               drop_count
`endif
);

    localparam int ptrWidth_c = $clog2(fifo_depth_c);
    localparam logic [fill_width_c-1:0] fillFull_c = fill_width_c'(fifo_depth_c);
    localparam logic [fill_width_c-1:0] fillOne_c  = fill_width_c'(1);
    localparam logic [ptrWidth_c-1:0]   ptrOne_c   = ptrWidth_c'(1);

    // Reject configurations the packing logic is not built for.
    if (bits_per_sym_c != 2) begin : g_badBitsPerSym
        $error("ofdm_rx_byte_packer: bits_per_sym_c must be 2");
    end
    if (fifo_depth_c < 4 || (fifo_depth_c & (fifo_depth_c - 1)) != 0) begin : g_badDepth
        $error("ofdm_rx_byte_packer: fifo_depth_c must be a power of 2 and at least 4");
    end

    typedef enum logic {
        IDLE,
        PACK
    } packState_e;

    packState_e        state_q;
    logic [1:0]        pairCount_q;
    logic [5:0]        acc_q;
    logic              sofPend_q;
    logic              pushValid_q;
    logic [7:0]        pushByte_q;
    logic              pushSof_q;
    logic              misalignErr_q;

    logic [8:0]                mem_q [fifo_depth_c];
    logic [ptrWidth_c-1:0]     wrPtr_q, wrPtr_d;
    logic [ptrWidth_c-1:0]     rdPtr_q, rdPtr_d;
    logic [fill_width_c-1:0]   fill_q, fill_d;
    logic                      ovfErr_q, ovfErr_d;

    logic startEvent;
    logic misalignEvent;
    logic headValid;
    logic popEvent;
    logic pushOk;
    logic dropEvent;

    // A start always opens a new symbol. It is a misalignment only if
    // pairs of an unfinished byte are still pending.
    assign startEvent    = !sys_init && rx_rcv_data_valid && rx_rcv_data_start;
    assign misalignEvent = startEvent && (state_q == PACK) && (pairCount_q != 2'd0);

    // FSM and packer. The completed byte is staged in pushByte_q/pushSof_q
    // for one clock, so the FIFO write happens one edge after the 4th pair.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            pairCount_q   <= 2'd0;
            acc_q         <= 6'd0;
            sofPend_q     <= 1'b0;
            pushValid_q   <= 1'b0;
            pushByte_q    <= 8'd0;
            pushSof_q     <= 1'b0;
            misalignErr_q <= 1'b0;
        end else if (sys_init) begin
            state_q       <= IDLE;
            pairCount_q   <= 2'd0;
            acc_q         <= 6'd0;
            sofPend_q     <= 1'b0;
            pushValid_q   <= 1'b0;
            pushByte_q    <= 8'd0;
            pushSof_q     <= 1'b0;
            misalignErr_q <= 1'b0;
        end else begin
            pushValid_q <= 1'b0;
            if (misalignEvent) begin
                misalignErr_q <= 1'b1;
            end else if (clear_err) begin
                misalignErr_q <= 1'b0;
            end
            if (rx_rcv_data_valid) begin
                if (rx_rcv_data_start) begin
                    state_q     <= PACK;
                    pairCount_q <= 2'd1;
                    acc_q       <= {4'd0, rx_rcv_data};
                    sofPend_q   <= 1'b1;
                end else if (state_q == PACK) begin
                    if (pairCount_q == 2'd3) begin
                        pushValid_q <= 1'b1;
                        pushByte_q  <= {acc_q, rx_rcv_data};
                        pushSof_q   <= sofPend_q;
                        pairCount_q <= 2'd0;
                        acc_q       <= 6'd0;
                        sofPend_q   <= 1'b0;
                    end else begin
                        acc_q       <= {acc_q[3:0], rx_rcv_data};
                        pairCount_q <= pairCount_q + 2'd1;
                    end
                end
            end
        end
    end

    // A write is accepted if the FIFO has room, or if a pop frees a slot
    // at the same edge.
    assign headValid = (fill_q != '0);
    assign popEvent  = headValid && out_ready;
    assign pushOk    = pushValid_q && ((fill_q != fillFull_c) || popEvent);
    assign dropEvent = pushValid_q && !pushOk;

    // FIFO next-state: pointers wrap naturally because the depth is a
    // power of two. A simultaneous push and pop leaves the fill unchanged.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        fill_d   = fill_q;
        ovfErr_d = ovfErr_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + ptrOne_c;
        end
        if (popEvent) begin
            rdPtr_d = rdPtr_q + ptrOne_c;
        end
        if (pushOk && !popEvent) begin
            fill_d = fill_q + fillOne_c;
        end else if (!pushOk && popEvent) begin
            fill_d = fill_q - fillOne_c;
        end
        if (dropEvent) begin
            ovfErr_d = 1'b1;
        end else if (clear_err) begin
            ovfErr_d = 1'b0;
        end
    end

    // FIFO control registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            fill_q   <= '0;
            ovfErr_q <= 1'b0;
        end else if (sys_init) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            fill_q   <= '0;
            ovfErr_q <= 1'b0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            fill_q   <= fill_d;
            ovfErr_q <= ovfErr_d;
        end
    end

    // Storage array. It has no reset: the outputs are masked while the
    // FIFO is empty, so stale contents are never visible.
    always_ff @(posedge sys_clk) begin
        if (pushOk && !sys_init) begin
            mem_q[wrPtr_q] <= {pushSof_q, pushByte_q};
        end
    end

    assign out_valid    = headValid;
    assign out_data     = headValid ? mem_q[rdPtr_q][7:0] : 8'd0;
    assign out_sof      = headValid ? mem_q[rdPtr_q][8] : 1'b0;
    assign fill_level   = fill_q;
    assign misalign_err = misalignErr_q;
    assign ovf_err      = ovfErr_q;

`ifdef RX_PACKER_STATS_EN
    logic [15:0] symCount_q;
    logic [15:0] dropCount_q;
    logic [1:0]  dropInc;
    logic [16:0] dropSum;

    // An overflow drop and a misalignment discard can occur in the same
    // cycle, so drop_count may advance by two.
    assign dropInc = {1'b0, misalignEvent} + {1'b0, dropEvent};
    assign dropSum = {1'b0, dropCount_q} + {15'd0, dropInc};

    // Saturating statistics counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            symCount_q  <= 16'd0;
            dropCount_q <= 16'd0;
        end else if (sys_init || clear_err) begin
            symCount_q  <= 16'd0;
            dropCount_q <= 16'd0;
        end else begin
            if (startEvent && symCount_q != 16'hFFFF) begin
                symCount_q <= symCount_q + 16'd1;
            end
            dropCount_q <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
        end
    end

    assign sym_count  = symCount_q;
    assign drop_count = dropCount_q;
`endif

endmodule
